// File: rtl/uart_frame_host.sv
// uart_frame_host
//   Host-side frame writer for a buffered UART transmit interface.
//   Builds the frame 0x55, 0xAA, LEN, payload[0..LEN-1], CHK and pushes it
//   byte by byte into the UART's 16-entry transmit buffer with TDR/LOCK_TDR
//   strobes. It then waits for the line to drain (TC high long enough) before
//   pulsing DONE.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START, LEN[3:0]     frame request (sampled in IDLE), payload length 0..11
//   PLD_WE/ADDR/DATA    payload register write port (ignored while BUSY)
//   BUSY, DONE, ERR     status: frame in flight, frame finished, bad LEN
//   TDR[7:0], LOCK_TDR  byte and write strobe towards the UART buffer
//   TC                  UART transmit-complete / line idle
`timescale 1ns/1ps

module uart_frame_host #(
  parameter int CLK_FREQ   = 100000000,
  parameter int UART_BPS   = 115200,
  parameter int STROBE_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] LEN,
  input  logic       PLD_WE,
  input  logic [3:0] PLD_ADDR,
  input  logic [7:0] PLD_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] TDR,
  output logic       LOCK_TDR,
  input  logic       TC
);

  // Twelve bit times per character gives margin over the 10-bit frame.
  localparam int DRAIN_CYC = 12 * CLK_FREQ / UART_BPS;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam int SW        = (STROBE_CYC < 2) ? 1 : $clog2(STROBE_CYC);
  localparam logic [SW-1:0] STB_LAST   = SW'(STROBE_CYC - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STB_H, S_STB_L, S_DRAIN, S_FIN
  } state_t;

  state_t        state_q;
  logic [3:0]    len_q;
  logic [3:0]    idx_q;
  logic [7:0]    chk_q;
  logic [7:0]    tdr_q;
  logic [SW-1:0] cnt_q;
  logic [DW-1:0] drain_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          lock_q;

  logic [7:0]    pld_q [12];
  logic [11:0]   pld_wr;

  // Per-register write decode; addresses 12..15 match nothing.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_pld_dec
      assign pld_wr[gi] = PLD_WE && !busy_q && (PLD_ADDR == 4'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 12; i++) pld_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (pld_wr[i]) pld_q[i] <= PLD_DATA;
      end
    end
  end

  // Next frame byte, selected by the index the byte will occupy.
  logic [3:0] nxt_idx_d;
  logic [3:0] last_idx;
  logic [3:0] pidx;
  logic [7:0] nxt_byte_d;
  logic       add_chk;

  always_comb begin
    nxt_idx_d = idx_q + 4'd1;
    last_idx  = len_q + 4'd3;
    pidx      = nxt_idx_d - 4'd3;
    add_chk   = (idx_q >= 4'd2) && (idx_q != last_idx);
    if (nxt_idx_d == 4'd1)          nxt_byte_d = 8'hAA;
    else if (nxt_idx_d == 4'd2)     nxt_byte_d = {4'h0, len_q};
    else if (nxt_idx_d == last_idx) nxt_byte_d = chk_q;
    else if (pidx < 4'd12)          nxt_byte_d = pld_q[pidx];
    else                            nxt_byte_d = 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      chk_q   <= 8'h00;
      tdr_q   <= 8'h00;
      cnt_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (LEN > 4'd11) begin
              err_q <= 1'b1;
            end else begin
              len_q   <= LEN;
              idx_q   <= 4'd0;
              chk_q   <= 8'h00;
              busy_q  <= 1'b1;
              tdr_q   <= 8'h55;   // byte 0 is presented during SETUP
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          // TDR already holds byte[idx]; fold it into the checksum.
          if (add_chk) chk_q <= chk_q + tdr_q;
          cnt_q   <= '0;
          lock_q  <= 1'b1;
          state_q <= S_STB_H;
        end
        S_STB_H: begin
          if (cnt_q == STB_LAST) begin
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            state_q <= S_STB_L;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STB_L: begin
          // TDR held through the low phase: the UART latches on the fall.
          if (cnt_q == STB_LAST) begin
            cnt_q <= '0;
            idx_q <= nxt_idx_d;
            if (nxt_idx_d == len_q + 4'd4) begin
              drain_q <= '0;
              state_q <= S_DRAIN;
            end else begin
              tdr_q   <= nxt_byte_d;
              state_q <= S_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Count consecutive TC-high cycles; brief inter-character dips restart it.
          if (TC) begin
            if (drain_q == DRAIN_LAST) begin
              drain_q <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end else begin
            drain_q <= '0;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign TDR      = tdr_q;
  assign LOCK_TDR = lock_q;

endmodule

// File: tb/tb_uart_frame_host.sv
`timescale 1ns/1ps

module tb_uart_frame_host;

  localparam int DRAIN_CYC  = 10416;
  localparam int STROBE_CYC = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [3:0] LEN = 4'd0;
  logic       PLD_WE = 1'b0;
  logic [3:0] PLD_ADDR = 4'd0;
  logic [7:0] PLD_DATA = 8'h00;
  logic       TC = 1'b1;
  logic       BUSY, DONE, ERR, LOCK_TDR;
  logic [7:0] TDR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_frame_host #(
    .CLK_FREQ  (100000000),
    .UART_BPS  (115200),
    .STROBE_CYC(STROBE_CYC)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .LEN     (LEN),
    .PLD_WE  (PLD_WE),
    .PLD_ADDR(PLD_ADDR),
    .PLD_DATA(PLD_DATA),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .TDR     (TDR),
    .LOCK_TDR(LOCK_TDR),
    .TC      (TC)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor: logs the byte at each LOCK_TDR rise, high/low run lengths,
  // TDR movement while the strobe is high or at its fall, and DONE samples.
  logic       lock_prev = 1'b0;
  logic [7:0] cur_byte  = 8'h00;
  int         hi_run = 0, lo_run = 0;
  logic [7:0] mon_bytes[$];
  int         mon_hi[$];
  int         mon_lo[$];
  int         fall_cnt = 0, last_fall = 0, tdr_moves = 0, done_cnt = 0;

  always @(negedge CLK) begin
    if (LOCK_TDR && !lock_prev) begin
      mon_bytes.push_back(TDR);
      cur_byte = TDR;
      if (fall_cnt > 0) mon_lo.push_back(lo_run);
      hi_run = 1;
    end else if (LOCK_TDR) begin
      hi_run++;
      if (TDR !== cur_byte) tdr_moves++;
    end else if (lock_prev) begin
      mon_hi.push_back(hi_run);
      fall_cnt++;
      last_fall = cyc;
      lo_run = 1;
      if (TDR !== cur_byte) tdr_moves++;
    end else begin
      lo_run++;
    end
    if (DONE === 1'b1) done_cnt++;
    lock_prev = LOCK_TDR;
  end

  task automatic clear_mon();
    @(negedge CLK);
    #1;
    mon_bytes.delete();
    mon_hi.delete();
    mon_lo.delete();
    fall_cnt  = 0;
    tdr_moves = 0;
    done_cnt  = 0;
  endtask

  task automatic write_pld(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    PLD_WE = 1'b1; PLD_ADDR = a; PLD_DATA = d;
    @(negedge CLK);
    PLD_WE = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] l);
    @(negedge CLK);
    START = 1'b1; LEN = l;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc, output bit ok);
    int n;
    ok = 1'b0; dc = 0; n = 0;
    while (!ok && n < budget) begin
      @(negedge CLK);
      n++;
      if (DONE === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
      end
    end
  endtask

  task automatic wait_falls(input int nf, input int budget, output bit ok);
    int n;
    ok = 1'b0; n = 0;
    while (!ok && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
      if (fall_cnt >= nf) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n, viol;
    repeat (3) @(negedge CLK);
    total++; if (LOCK_TDR !== 1'b0) begin bad++; $display("FAIL rst_lock: got %b expected 0", LOCK_TDR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
    total++; if (DONE !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL rst_done_err: got %b%b expected 00", DONE, ERR); end
    total++; if (TDR !== 8'h00) begin bad++; $display("FAIL rst_tdr: got %h expected 00", TDR); end
    RST_N = 1'b1;
    write_pld(4'd0, 8'h11);   // cleared again by the mid-frame reset below
    pulse_start(4'd2);
    n = 0;
    while (LOCK_TDR !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    total++; if (LOCK_TDR !== 1'b1) begin bad++; $display("FAIL rst_reach_stbh: got %b expected 1", LOCK_TDR); end
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    total++; if (LOCK_TDR !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL rst_async_lock_busy: got %b%b expected 00", LOCK_TDR, BUSY); end
    total++; if (TDR !== 8'h00 || DONE !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL rst_async_tdr: got %h %b%b expected 00 00", TDR, DONE, ERR); end
    @(negedge CLK);
    RST_N = 1'b1;
    viol = 0;
    repeat (40) begin
      @(negedge CLK);
      if (LOCK_TDR !== 1'b0 || BUSY !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL rst_quiet: got %0d active cycles expected 0", viol); end
    $display("test_reset: done");
  endtask

  // LEN=1 with payload untouched since reset (P0=0x00); TC dips three times.
  task automatic test_drain();
    logic [7:0] exp_b[$];
    bit ok;
    int dc, last_drop;
    exp_b = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01};
    clear_mon();
    TC = 1'b1;
    pulse_start(4'd1);
    wait_falls(5, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_push: got %0d falls expected 5", fall_cnt); end
    last_drop = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (5000) @(negedge CLK);
      TC = 1'b0;
      last_drop = cyc;
      @(negedge CLK);
      TC = 1'b1;
    end
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL drain_early: got %0d DONE samples expected 0", done_cnt); end
    wait_done(11000, dc, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_timeout: got no DONE expected DONE"); end
    // TC low is seen at the edge after last_drop; DRAIN_CYC high edges follow.
    total++; if (dc != last_drop + DRAIN_CYC + 1) begin bad++; $display("FAIL drain_time: got %0d expected %0d", dc - last_drop, DRAIN_CYC + 1); end
    @(negedge CLK); #1;
    total++; if (mon_bytes.size() != exp_b.size()) begin bad++; $display("FAIL drain_count: got %0d expected %0d", mon_bytes.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < mon_bytes.size(); i++) begin
      total++; if (mon_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL drain_byte%0d: got %h expected %h", i, mon_bytes[i], exp_b[i]); end
    end
    $display("test_drain: done at %0d cycles after last drop", dc - last_drop);
  endtask

  task automatic test_len2();
    logic [7:0] exp_b[$];
    bit ok;
    int dc;
    exp_b = '{8'h55, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h35};
    write_pld(4'd0, 8'h11);
    write_pld(4'd1, 8'h22);
    clear_mon();
    TC = 1'b1;
    pulse_start(4'd2);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL len2_busy: got %b expected 1", BUSY); end
    wait_done(12000, dc, ok);
    total++; if (!ok) begin bad++; $display("FAIL len2_timeout: got no DONE expected DONE"); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL len2_busy_at_done: got %b expected 0", BUSY); end
    // Last fall is followed by STROBE_CYC low cycles, then DRAIN_CYC in DRAIN.
    total++; if (dc - last_fall != DRAIN_CYC + STROBE_CYC) begin bad++; $display("FAIL len2_drain: got %0d expected %0d", dc - last_fall, DRAIN_CYC + STROBE_CYC); end
    @(negedge CLK); #1;
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL len2_done_width: got %b expected 0", DONE); end
    total++; if (mon_bytes.size() != 6) begin bad++; $display("FAIL len2_count: got %0d expected 6", mon_bytes.size()); end
    for (int i = 0; i < exp_b.size() && i < mon_bytes.size(); i++) begin
      total++; if (mon_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL len2_byte%0d: got %h expected %h", i, mon_bytes[i], exp_b[i]); end
    end
    for (int i = 0; i < mon_hi.size(); i++) begin
      total++; if (mon_hi[i] != STROBE_CYC) begin bad++; $display("FAIL len2_high%0d: got %0d expected %0d", i, mon_hi[i], STROBE_CYC); end
    end
    // Gap between pulses: STROBE_CYC low cycles of STB_L plus the SETUP cycle.
    for (int i = 0; i < mon_lo.size(); i++) begin
      total++; if (mon_lo[i] != STROBE_CYC + 1) begin bad++; $display("FAIL len2_low%0d: got %0d expected %0d", i, mon_lo[i], STROBE_CYC + 1); end
    end
    total++; if (tdr_moves != 0) begin bad++; $display("FAIL len2_tdr_stable: got %0d changes expected 0", tdr_moves); end
    $display("test_len2: %0d bytes, done %0d cycles after last fall", mon_bytes.size(), dc - last_fall);
  endtask

  task automatic test_len11();
    logic [7:0] exp_b[$];
    bit ok;
    int dc;
    exp_b = '{8'h55, 8'hAA, 8'h0B};
    for (int i = 0; i < 11; i++) exp_b.push_back(8'hFF);
    exp_b.push_back(8'h00);
    for (int i = 0; i < 11; i++) write_pld(4'(i), 8'hFF);
    clear_mon();
    pulse_start(4'd11);
    wait_done(12000, dc, ok);
    total++; if (!ok) begin bad++; $display("FAIL len11_timeout: got no DONE expected DONE"); end
    @(negedge CLK); #1;
    total++; if (mon_bytes.size() != 15) begin bad++; $display("FAIL len11_count: got %0d expected 15", mon_bytes.size()); end
    for (int i = 0; i < exp_b.size() && i < mon_bytes.size(); i++) begin
      total++; if (mon_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL len11_byte%0d: got %h expected %h", i, mon_bytes[i], exp_b[i]); end
    end
    $display("test_len11: %0d bytes", mon_bytes.size());
  endtask

  task automatic test_len0();
    logic [7:0] exp_b[$];
    bit ok;
    int dc;
    exp_b = '{8'h55, 8'hAA, 8'h00, 8'h00};
    clear_mon();
    pulse_start(4'd0);
    wait_done(12000, dc, ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_timeout: got no DONE expected DONE"); end
    @(negedge CLK); #1;
    total++; if (mon_bytes.size() != 4) begin bad++; $display("FAIL len0_count: got %0d expected 4", mon_bytes.size()); end
    for (int i = 0; i < exp_b.size() && i < mon_bytes.size(); i++) begin
      total++; if (mon_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL len0_byte%0d: got %h expected %h", i, mon_bytes[i], exp_b[i]); end
    end
    $display("test_len0: %0d bytes", mon_bytes.size());
  endtask

  task automatic test_err();
    int viol;
    clear_mon();
    @(negedge CLK);
    START = 1'b1; LEN = 4'd12;
    @(negedge CLK);
    START = 1'b0;
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b expected 1", ERR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL err_busy: got %b expected 0", BUSY); end
    @(negedge CLK);
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL err_width: got %b expected 0", ERR); end
    viol = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || LOCK_TDR !== 1'b0) viol++;
    end
    #1;
    total++; if (viol != 0 || mon_bytes.size() != 0) begin bad++; $display("FAIL err_quiet: got %0d active, %0d bytes expected 0, 0", viol, mon_bytes.size()); end
    $display("test_err: LEN=12 rejected");
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp_b[$];
    bit ok;
    int dc, viol;
    exp_b = '{8'h55, 8'hAA, 8'h02, 8'h5A, 8'h3C, 8'h98};
    write_pld(4'd0, 8'h5A);
    write_pld(4'd1, 8'h3C);
    clear_mon();
    pulse_start(4'd2);
    repeat (2) @(negedge CLK);
    write_pld(4'd0, 8'h99);
    pulse_start(4'd1);
    wait_done(12000, dc, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no DONE expected DONE"); end
    viol = 0;
    repeat (30) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || LOCK_TDR !== 1'b0) viol++;
    end
    #1;
    total++; if (viol != 0) begin bad++; $display("FAIL busy_second_start: got %0d active cycles expected 0", viol); end
    total++; if (mon_bytes.size() != 6) begin bad++; $display("FAIL busy_count: got %0d expected 6", mon_bytes.size()); end
    for (int i = 0; i < exp_b.size() && i < mon_bytes.size(); i++) begin
      total++; if (mon_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL busy_byte%0d: got %h expected %h", i, mon_bytes[i], exp_b[i]); end
    end
    $display("test_busy_ignore: %0d bytes", mon_bytes.size());
  endtask

  initial begin
    test_reset();
    test_drain();
    test_len2();
    test_len11();
    test_len0();
    test_err();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
